// File: rtl/mmu_line_arbiter.sv
// ---------------------------------------------------------------------------
// mmu_line_arbiter
//
// Memory-side stage below the L1 caches. Accepts 256-bit line requests from
// the I-cache (read only) and the D-cache (read / write-back), arbitrates
// round-robin between them and drives a single-port line-wide BRAM.
//
// Ports
//   sys_clk, rst_n        clock, asynchronous active-low reset
//   i_req_read/i_req_addr I-cache line read request (level) and byte address
//   i_read_done           one-cycle I completion pulse
//   i_read_data           returned I line, held until the next I read
//   d_req_read/d_req_write D-cache read / write-back request (level)
//   d_req_addr/d_write_data D-cache byte address and write line
//   d_read_done/d_write_done one-cycle D completion pulses
//   d_read_data           returned D line, held until the next D read
//   ram_addr/ram_din/ram_we/ram_dout  BRAM line port
//   busy                  high whenever the block is not idle
// ---------------------------------------------------------------------------
module mmu_line_arbiter #(
    parameter int RAM_LATENCY = 2,
    parameter int LINE_ADDR_W = 12
) (
    input  logic                   sys_clk,
    input  logic                   rst_n,
    input  logic                   i_req_read,
    input  logic [31:0]            i_req_addr,
    output logic                   i_read_done,
    output logic [255:0]           i_read_data,
    input  logic                   d_req_read,
    input  logic                   d_req_write,
    input  logic [31:0]            d_req_addr,
    input  logic [255:0]           d_write_data,
    output logic                   d_read_done,
    output logic                   d_write_done,
    output logic [255:0]           d_read_data,
    output logic [LINE_ADDR_W-1:0] ram_addr,
    output logic [255:0]           ram_din,
    output logic                   ram_we,
    input  logic [255:0]           ram_dout,
    output logic                   busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic       CL_I   = 1'b0;
    localparam logic       CL_D   = 1'b1;
    localparam logic [2:0] LAT_M1 = 3'(RAM_LATENCY - 1);

    state_t r_state;
    state_t w_next;

    logic [2:0] r_cnt;
    logic       r_client;      // client of the transaction in flight
    logic       r_last;        // client granted most recently
    logic       r_after_done;  // previous cycle was DONE

    logic                   w_mask;
    logic                   w_i_elig;
    logic                   w_d_elig;
    logic                   w_can_grant;
    logic                   w_grant;
    logic                   w_gnt_d;
    logic                   w_gnt_wr;
    logic                   w_rd_last;
    logic [LINE_ADDR_W-1:0] w_gnt_line;
    logic                   w_unused;

    // The client just served is blocked while DONE and during the cycle
    // after it: the L1 only drops its request once it has seen done.
    assign w_mask   = (r_state == S_DONE) || r_after_done;
    assign w_i_elig = i_req_read && !(w_mask && (r_last == CL_I));
    assign w_d_elig = (d_req_read || d_req_write) && !(w_mask && (r_last == CL_D));

    // DONE doubles as an arbitration slot so the other client can follow
    // without a dead cycle.
    assign w_can_grant = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_grant     = w_can_grant && (w_i_elig || w_d_elig);
    assign w_gnt_d     = w_d_elig && (!w_i_elig || (r_last == CL_I));
    assign w_gnt_wr    = w_gnt_d && d_req_write;   // write beats read
    assign w_gnt_line  = w_gnt_d ? d_req_addr[5 +: LINE_ADDR_W]
                                 : i_req_addr[5 +: LINE_ADDR_W];
    assign w_rd_last   = (r_state == S_READ_WAIT) && (r_cnt == 3'd0);

    // Offset bits and bits above the line index are deliberately ignored.
    assign w_unused = ^{i_req_addr, d_req_addr};

    assign busy = (r_state != S_IDLE);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_grant) begin
                    w_next = w_gnt_wr ? S_WRITE : S_READ_WAIT;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_READ_WAIT: begin
                if (r_cnt == 3'd0) begin
                    w_next = S_DONE;
                end
            end
            S_WRITE: begin
                w_next = S_DONE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= 3'd0;
            r_client     <= CL_I;
            r_last       <= CL_I;
            r_after_done <= 1'b0;
            ram_addr     <= '0;
            ram_din      <= '0;
            ram_we       <= 1'b0;
            i_read_done  <= 1'b0;
            d_read_done  <= 1'b0;
            d_write_done <= 1'b0;
            i_read_data  <= '0;
            d_read_data  <= '0;
        end else begin
            ram_we       <= 1'b0;
            i_read_done  <= 1'b0;
            d_read_done  <= 1'b0;
            d_write_done <= 1'b0;
            r_after_done <= (r_state == S_DONE);

            // The line index and write data are captured here so later
            // changes on the request inputs cannot disturb the transaction.
            if (w_grant) begin
                r_client <= w_gnt_d;
                r_last   <= w_gnt_d;
                ram_addr <= w_gnt_line;
                r_cnt    <= LAT_M1;
                if (w_gnt_wr) begin
                    ram_din <= d_write_data;
                    ram_we  <= 1'b1;
                end
            end else if ((r_state == S_READ_WAIT) && (r_cnt != 3'd0)) begin
                r_cnt <= r_cnt - 3'd1;
            end

            if (w_rd_last) begin
                if (r_client == CL_D) begin
                    d_read_data <= ram_dout;
                    d_read_done <= 1'b1;
                end else begin
                    i_read_data <= ram_dout;
                    i_read_done <= 1'b1;
                end
            end

            if (r_state == S_WRITE) begin
                d_write_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mmu_line_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mmu_line_arbiter
//
// Drives mmu_line_arbiter through directed scenarios and a randomized phase
// and compares every output, every cycle, against a transaction-level model:
// one server, round-robin choice, fixed service times and per-client
// re-eligibility times, with a shadow memory holding line contents.
// ---------------------------------------------------------------------------
module tb_mmu_line_arbiter;

    localparam int L = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_req;
    logic [31:0]  i_addr;
    logic         i_read_done;
    logic [255:0] i_read_data;
    logic         d_rd;
    logic         d_wr;
    logic [31:0]  d_addr;
    logic [255:0] d_wdata;
    logic         d_read_done;
    logic         d_write_done;
    logic [255:0] d_read_data;
    logic [11:0]  ram_addr;
    logic [255:0] ram_din;
    logic         ram_we;
    logic [255:0] ram_dout;
    logic         busy;

    always #5 clk = ~clk;

    mmu_line_arbiter #(
        .RAM_LATENCY(L),
        .LINE_ADDR_W(12)
    ) dut (
        .sys_clk     (clk),
        .rst_n       (rst_n),
        .i_req_read  (i_req),
        .i_req_addr  (i_addr),
        .i_read_done (i_read_done),
        .i_read_data (i_read_data),
        .d_req_read  (d_rd),
        .d_req_write (d_wr),
        .d_req_addr  (d_addr),
        .d_write_data(d_wdata),
        .d_read_done (d_read_done),
        .d_write_done(d_write_done),
        .d_read_data (d_read_data),
        .ram_addr    (ram_addr),
        .ram_din     (ram_din),
        .ram_we      (ram_we),
        .ram_dout    (ram_dout),
        .busy        (busy)
    );

    function automatic logic [255:0] line_pat(input logic [11:0] k);
        logic [255:0] r;
        for (int w = 0; w < 8; w++) begin
            r[w*32 +: 32] = {k, 4'(w), 16'h5A00 + 16'(w)};
        end
        return r;
    endfunction

    // BRAM with L-cycle read latency; unwritten lines read as line_pat.
    logic [255:0] mem [4096];
    bit           wr_flag [4096];
    logic [255:0] pipe [L-1];

    always @(posedge clk) begin
        pipe[0] <= wr_flag[ram_addr] ? mem[ram_addr] : line_pat(ram_addr);
        for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
        if (ram_we) begin
            mem[ram_addr]     <= ram_din;
            wr_flag[ram_addr] <= 1'b1;
        end
    end
    assign ram_dout = pipe[L-2];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model state
    logic [255:0] shadow [4096];
    int           t, F, blk_i, blk_d, tg, tc;
    bit           last_d, tv, tcl, top;
    logic [11:0]  tline;
    logic [255:0] twd;
    logic         e_idone, e_drd, e_dwd, e_we, e_busy;
    logic [11:0]  e_addr;
    logic [255:0] e_din, e_idata, e_ddata;

    task automatic model_reset();
        t = 0; F = 1; blk_i = 0; blk_d = 0; last_d = 1'b0; tv = 1'b0;
        e_idone = 0; e_drd = 0; e_dwd = 0; e_we = 0; e_busy = 0;
        e_addr = '0; e_din = '0; e_idata = '0; e_ddata = '0;
    endtask

    task automatic cmp_all();
        chk("i_read_done", i_read_done, e_idone);
        chk("d_read_done", d_read_done, e_drd);
        chk("d_write_done", d_write_done, e_dwd);
        chk("ram_we", ram_we, e_we);
        chk("busy", busy, e_busy);
        chk("ram_addr", ram_addr, e_addr);
        chk("ram_din", ram_din, e_din);
        chk("i_read_data", i_read_data, e_idata);
        chk("d_read_data", d_read_data, e_ddata);
    endtask

    // One clock edge: predict what that edge does, then compare.
    task automatic step();
        bit gi, gd;
        t++;
        e_idone = 0; e_drd = 0; e_dwd = 0; e_we = 0;
        if (tv && t == tc) begin
            if (top) begin
                shadow[tline] = twd;
                e_dwd = 1;
            end else if (tcl) begin
                e_ddata = shadow[tline];
                e_drd = 1;
            end else begin
                e_idata = shadow[tline];
                e_idone = 1;
            end
        end
        if (t >= F) begin
            gi = i_req && (t >= blk_i);
            gd = (d_rd || d_wr) && (t >= blk_d);
            if (gi || gd) begin
                if (gi && gd) tcl = !last_d;
                else          tcl = gd;
                top   = tcl && d_wr;
                tline = tcl ? d_addr[16:5] : i_addr[16:5];
                twd   = d_wdata;
                tv    = 1;
                tg    = t;
                tc    = t + (top ? 1 : L);
                F     = tc + 1;
                if (tcl) blk_d = tc + 3;
                else     blk_i = tc + 3;
                last_d = tcl;
                e_addr = tline;
                if (top) begin
                    e_din = twd;
                    e_we  = 1;
                end
            end
        end
        e_busy = tv && (t <= tc);
        @(posedge clk);
        @(negedge clk);
        cmp_all();
    endtask

    task automatic drop_on_done();
        if (e_idone) i_req = 0;
        if (e_drd || e_dwd) begin
            d_rd = 0;
            d_wr = 0;
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            step();
            drop_on_done();
        end
    endtask

    // which: 0 = i_read_done, 1 = d_read_done, 2 = d_write_done
    task automatic wait_done(input int which, input int maxc, input string tag);
        bit seen = 0;
        for (int k = 0; k < maxc && !seen; k++) begin
            step();
            seen = (which == 0) ? i_read_done : (which == 1) ? d_read_done : d_write_done;
            drop_on_done();
        end
        chk(tag, seen, 1'b1);
    endtask

    task automatic do_reset();
        rst_n = 0;
        i_req = 0; d_rd = 0; d_wr = 0;
        model_reset();
        #1;
        cmp_all();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFE0000) | (32'($urandom_range(15)) << 5) | 32'($urandom_range(31));
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int w = 0; w < 8; w++) r[w*32 +: 32] = $urandom;
        return r;
    endfunction

    int     cnt;
    int     seq[$];
    logic [255:0] pat_ab;

    initial begin
        i_req = 0; i_addr = 0; d_rd = 0; d_wr = 0; d_addr = 0; d_wdata = '0;
        for (int k = 0; k < 4096; k++) shadow[k] = line_pat(12'(k));
        pat_ab = {8{32'hAAAABBBB}};

        // Reset values, then D write followed by D read of the same line
        @(negedge clk);
        do_reset();
        d_wr = 1; d_addr = 32'h0000200C; d_wdata = pat_ab;
        wait_done(2, 10, "wr_wait");
        d_rd = 1; d_addr = 32'h0000200C;
        wait_done(1, 12, "rd_wait");
        chk("wr_rd_data", d_read_data, pat_ab);
        run(3);

        // Simultaneous reads right after reset: D first, then I
        do_reset();
        i_req = 1; i_addr = 32'h00000000;
        d_rd = 1;  d_addr = 32'h00004000;
        seq.delete();
        for (int k = 0; k < 10; k++) begin
            step();
            if (d_read_done) seq.push_back(1);
            if (i_read_done) seq.push_back(0);
            drop_on_done();
        end
        chk("simul_count", 32'(seq.size()), 32'd2);
        if (seq.size() == 2) begin
            chk("simul_first_d", 32'(seq[0]), 32'd1);
            chk("simul_second_i", 32'(seq[1]), 32'd0);
        end
        chk("simul_i_data", i_read_data, line_pat(12'h000));
        chk("simul_d_data", d_read_data, line_pat(12'h200));

        // Fairness: both held continuously for 6 transactions
        i_req = 1; i_addr = 32'h00000060;
        d_rd = 1;  d_addr = 32'h00000080;
        seq.delete();
        for (int k = 0; k < 30 && seq.size() < 6; k++) begin
            step();
            chk("no_double", 32'(i_read_done & d_read_done), 32'd0);
            if (d_read_done) seq.push_back(1);
            if (i_read_done) seq.push_back(0);
        end
        chk("fair_count", 32'(seq.size()), 32'd6);
        foreach (seq[k]) chk("fair_order", 32'(seq[k]), (k % 2 == 0) ? 32'd1 : 32'd0);
        i_req = 0; d_rd = 0;
        run(6);

        // Both D ops high: write performed, only write done pulses
        d_rd = 1; d_wr = 1; d_addr = 32'h00000300; d_wdata = rand_line();
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (d_read_done) cnt++;
            drop_on_done();
        end
        chk("both_no_rdone", 32'(cnt), 32'd0);

        // Address changed and request dropped mid-read
        i_req = 1; i_addr = 32'h00000020;
        cnt = 0;
        step();
        i_addr = 32'h00000040;
        step();
        i_req = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (i_read_done) cnt++;
        end
        chk("withdraw_done_cnt", 32'(cnt), 32'd1);
        chk("withdraw_line", i_read_data, line_pat(12'h001));

        // Reset pulled during the WRITE cycle
        d_wr = 1; d_addr = 32'h00000060; d_wdata = rand_line();
        step();
        #2;
        rst_n = 0;
        d_wr = 0;
        model_reset();
        #1;
        chk("rst_we_async", ram_we, 1'b0);
        cmp_all();
        @(negedge clk);
        rst_n = 1;
        cnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (d_write_done) cnt++;
        end
        chk("rst_no_done", 32'(cnt), 32'd0);
        d_rd = 1; d_addr = 32'h00000060;
        wait_done(1, 10, "post_rst_rd");
        chk("post_rst_data", d_read_data, line_pat(12'h003));
        run(3);

        // Randomized traffic
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            step();
            if (e_idone && $urandom_range(3) != 0) i_req = 0;
            if ((e_drd || e_dwd) && $urandom_range(3) != 0) begin
                d_rd = 0; d_wr = 0;
            end
            if (!i_req && $urandom_range(2) == 0) begin
                i_req = 1; i_addr = rand_addr();
            end
            if (!d_rd && !d_wr && $urandom_range(2) == 0) begin
                case ($urandom_range(3))
                    0:       d_rd = 1;
                    3:       begin d_rd = 1; d_wr = 1; end
                    default: d_wr = 1;
                endcase
                d_addr = rand_addr(); d_wdata = rand_line();
            end
            if ($urandom_range(15) == 0) i_addr = rand_addr();
            if ($urandom_range(15) == 0) d_addr = rand_addr();
            if ($urandom_range(15) == 0) d_wdata = rand_line();
            if ($urandom_range(31) == 0) i_req = 0;
            if ($urandom_range(31) == 0) begin d_rd = 0; d_wr = 0; end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
